// File: rtl/fan_pkg.sv
// ---------------------------------------------------------------------------
// fan_pkg
// Shared types and constants for the fan PWM path. The timebase and the
// downstream comparator both take their default PERIOD / PRESCALE from here,
// so that the duty thresholds always match the counter modulus.
//
// Contents:
//   fan_level_e     - applied fan level (off / 33% / 66% / 99%)
//   fan_state_e     - timebase run-control state
//   FAN_*_DEF       - default PWM period, prescale and counter width
//   level_ramp_step - one soft-start step from the current level toward a target
// ---------------------------------------------------------------------------
package fan_pkg;

    typedef enum logic [1:0] {
        FAN_OFF = 2'd0,
        FAN_33  = 2'd1,
        FAN_66  = 2'd2,
        FAN_99  = 2'd3
    } fan_level_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } fan_state_e;

    localparam int FAN_PRESCALE_DEF = 100;
    localparam int FAN_PERIOD_DEF   = 1000;
    localparam int FAN_CNT_W_DEF    = 10;

    // Rising by more than one level is limited to a single step; anything
    // else (hold, +1, any decrease) lands on the target directly.
    function automatic logic [1:0] level_ramp_step(input logic [1:0] cur,
                                                   input logic [1:0] target);
        logic [2:0] cur_plus_one;
        cur_plus_one = {1'b0, cur} + 3'd1;
        if ({1'b0, target} > cur_plus_one)
            return cur + 2'd1;
        return target;
    endfunction

endpackage

// File: rtl/fan_prescaler.sv
// ---------------------------------------------------------------------------
// fan_prescaler
// Divides the system clock down to the PWM counter increment rate. Counts
// 0..PRESCALE-1 while enabled and pulses tick during the terminal-count
// cycle. Held at 0 whenever disabled, so a fresh enable always starts a
// full prescale interval.
//
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset
//   enable  in  count enable (timebase is running or stopping)
//   tick    out high for the cycle in which the prescaler is at terminal count
// ---------------------------------------------------------------------------
module fan_prescaler
    import fan_pkg::*;
#(
    parameter int PRESCALE = FAN_PRESCALE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] count_q;

    assign tick = enable && (count_q == PS_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (!enable || tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + PS_W'(1);
        end
    end

endmodule

// File: rtl/fan_pwm_timebase.sv
// ---------------------------------------------------------------------------
// fan_pwm_timebase
// Free-running PWM timebase for the fan comparator stage. Produces the
// counter (0..PERIOD-1), an increment tick, a period-start strobe, and the
// fan level currently applied. Level requests are captured at any time but
// only take effect at a period boundary so the fan output never glitches
// mid-period.
//
// Build option:
//   FAN_SOFTSTART_EN - when defined, upward level changes of more than one
//                      step ramp by one level per period.
//
// Ports:
//   i_clk           in  system clock
//   i_reset         in  synchronous, active-high reset
//   i_en            in  run request (level-sensitive)
//   i_level_valid   in  qualifies i_level_req for one cycle
//   i_level_req     in  requested level (0=off, 1=33%, 2=66%, 3=99%)
//   o_counter       out PWM counter
//   o_tick          out one-cycle pulse per counter increment
//   o_period_start  out one-cycle pulse in the cycle the counter shows 0
//   o_level         out level currently applied
//   o_running       out high in RUN or STOPPING
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | stopped; counter, prescaler and level held at 0
// RUN      | counting; level follows the pending request at each wrap
// STOPPING | run request dropped; finish current period, then go IDLE
// ---------------------------------------------------------------------------
module fan_pwm_timebase
    import fan_pkg::*;
#(
    parameter int PRESCALE = FAN_PRESCALE_DEF,
    parameter int PERIOD   = FAN_PERIOD_DEF,
    parameter int CNT_W    = FAN_CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_level_valid,
    input  logic [1:0]       i_level_req,
    output logic [CNT_W-1:0] o_counter,
    output logic             o_tick,
    output logic             o_period_start,
    output logic [1:0]       o_level,
    output logic             o_running
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    fan_state_e       state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [1:0]       level_q, level_d;
    logic [1:0]       pend_q, pend_next;
    logic [1:0]       level_applied;
    logic             period_start_q, period_start_d;
    logic             active;
    logic             tick;
    logic             wrap;

    assign active = (state_q != ST_IDLE);

    fan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (i_clk),
        .reset  (i_reset),
        .enable (active),
        .tick   (tick)
    );

    assign wrap = tick && (counter_q == CNT_LAST);

    // A request arriving in the same cycle as a wrap (or an IDLE exit) is
    // used immediately rather than waiting a whole period.
    assign pend_next = i_level_valid ? i_level_req : pend_q;

`ifdef FAN_SOFTSTART_EN
    // level_q is 0 in IDLE, so entry from IDLE uses the same step rule.
    assign level_applied = level_ramp_step(level_q, pend_next);
`else
    assign level_applied = pend_next;
`endif

    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        level_d        = level_q;
        period_start_d = 1'b0;

        if (tick) begin
            counter_d = wrap ? '0 : counter_q + CNT_W'(1);
            if (wrap) begin
                period_start_d = 1'b1;
                level_d        = level_applied;
            end
        end

        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                level_d   = 2'd0;
                if (i_en) begin
                    state_d        = ST_RUN;
                    level_d        = level_applied;
                    period_start_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!i_en)
                    state_d = ST_STOPPING;
            end
            ST_STOPPING: begin
                // Reasserting the run request wins over the wrap, so the
                // timebase simply carries on as if it had never stopped.
                if (i_en) begin
                    state_d = ST_RUN;
                end else if (wrap) begin
                    state_d        = ST_IDLE;
                    counter_d      = '0;
                    level_d        = 2'd0;
                    period_start_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            counter_q      <= '0;
            level_q        <= 2'd0;
            pend_q         <= 2'd0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            level_q        <= level_d;
            pend_q         <= pend_next;
            period_start_q <= period_start_d;
        end
    end

    assign o_counter      = counter_q;
    assign o_tick         = tick;
    assign o_period_start = period_start_q;
    assign o_level        = level_q;
    assign o_running      = active;

endmodule

// File: tb/tb_fan_pwm_timebase.sv
// ---------------------------------------------------------------------------
// tb_fan_pwm_timebase
// Directed bench for fan_pwm_timebase with PRESCALE=4, PERIOD=10. A model
// tracks the elapsed cycles within the PWM frame and derives counter, tick
// and period-start from that by arithmetic; the fan level is updated at frame
// boundaries. Literal checks at key points pin the model.
// ---------------------------------------------------------------------------
module tb_fan_pwm_timebase;
    import fan_pkg::*;

    localparam int PS    = 4;
    localparam int PER   = 10;
    localparam int CW    = 4;
    localparam int FRAME = PS * PER;
`ifdef FAN_SOFTSTART_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          en     = 1'b0;
    logic          lvalid = 1'b0;
    logic [1:0]    lreq   = 2'd0;
    logic [CW-1:0] o_counter;
    logic          o_tick;
    logic          o_period_start;
    logic [1:0]    o_level;
    logic          o_running;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fan_pwm_timebase #(
        .PRESCALE (PS),
        .PERIOD   (PER),
        .CNT_W    (CW)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_en           (en),
        .i_level_valid  (lvalid),
        .i_level_req    (lreq),
        .o_counter      (o_counter),
        .o_tick         (o_tick),
        .o_period_start (o_period_start),
        .o_level        (o_level),
        .o_running      (o_running)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    bit m_armed    = 1'b0;
    bit m_active   = 1'b0;
    bit m_stopping = 1'b0;
    int m_phase    = 0;
    int m_level    = 0;
    int m_pend     = 0;

    function automatic int apply_level(input int cur, input int target);
        if (SOFT && target > cur + 1)
            return cur + 1;
        return target;
    endfunction

    always @(posedge clk) begin
        int req_now;
        bit n_active;
        bit n_stop;
        int n_phase;
        int n_level;
        req_now  = lvalid ? int'(lreq) : m_pend;
        n_active = m_active;
        n_stop   = m_stopping;
        n_phase  = m_phase;
        n_level  = m_level;
        if (reset) begin
            n_active = 1'b0;
            n_stop   = 1'b0;
            n_phase  = 0;
            n_level  = 0;
            req_now  = 0;
        end else if (!m_active) begin
            if (en) begin
                n_active = 1'b1;
                n_stop   = 1'b0;
                n_phase  = 0;
                n_level  = apply_level(0, req_now);
            end
        end else begin
            n_stop = !en;
            if (m_phase == FRAME - 1) begin
                n_phase = 0;
                if (m_stopping && !en) begin
                    n_active = 1'b0;
                    n_level  = 0;
                end else begin
                    n_level = apply_level(m_level, req_now);
                end
            end else begin
                n_phase = m_phase + 1;
            end
        end
        m_armed    <= m_armed | reset;
        m_active   <= n_active;
        m_stopping <= n_stop;
        m_phase    <= n_phase;
        m_level    <= n_level;
        m_pend     <= req_now;
    end

    always @(negedge clk) begin
        if (m_armed) begin
            chk("m_counter", int'(o_counter), m_active ? (m_phase / PS) % PER : 0);
            chk("m_tick", int'(o_tick), (m_active && (m_phase % PS == PS - 1)) ? 1 : 0);
            chk("m_period_start", int'(o_period_start), (m_active && m_phase == 0) ? 1 : 0);
            chk("m_level", int'(o_level), m_level);
            chk("m_running", int'(o_running), m_active ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cnt(input int val);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(o_counter) != val && n < 200);
        chk("wait_cnt_reached", (int'(o_counter) == val) ? 1 : 0, 1);
    endtask

    task automatic pulse_req(input logic [1:0] v);
        lvalid = 1'b1;
        lreq   = v;
        @(negedge clk);
        lvalid = 1'b0;
    endtask

    initial begin
        int n;
        int ticks;

        reset = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_counter", int'(o_counter), 0);
        chk("rst_running", int'(o_running), 0);
        chk("rst_period_start", int'(o_period_start), 0);
        chk("rst_level", int'(o_level), 0);
        chk("rst_tick", int'(o_tick), 0);

        // release with a same-cycle request: entry at level 1
        reset  = 1'b0;
        lvalid = 1'b1;
        lreq   = 2'd1;
        @(negedge clk);
        lvalid = 1'b0;
        chk("entry_period_start", int'(o_period_start), 1);
        chk("entry_counter", int'(o_counter), 0);
        chk("entry_level", int'(o_level), 1);
        chk("entry_running", int'(o_running), 1);

        n = 0;
        ticks = 0;
        do begin
            @(negedge clk);
            n++;
            if (o_tick) ticks++;
        end while (!o_period_start && n < 100);
        chk("period_len", n, 40);
        chk("ticks_per_period", ticks, 10);

        // request 3 mid-period: held until the wrap
        wait_cnt(4);
        pulse_req(2'd3);
        wait_cnt(9);
        chk("lvl_before_wrap", int'(o_level), 1);
        wait_cnt(0);
        chk("lvl_at_wrap", int'(o_level), SOFT ? 2 : 3);
        chk("wrap_period_start", int'(o_period_start), 1);

        // last request in a period wins
        wait_cnt(2);
        pulse_req(2'd2);
        wait_cnt(5);
        pulse_req(2'd0);
        wait_cnt(0);
        chk("last_req_wins", int'(o_level), 0);

        // request in the exact wrap cycle is applied at that wrap
        wait_cnt(9);
        repeat (3) @(negedge clk);
        chk("tick_at_wrap_cycle", int'(o_tick), 1);
        pulse_req(2'd2);
        chk("bypass_counter", int'(o_counter), 0);
        chk("bypass_level", int'(o_level), SOFT ? 1 : 2);
        chk("bypass_period_start", int'(o_period_start), 1);

        // stop: run to end of period, then idle
        wait_cnt(3);
        en = 1'b0;
        wait_cnt(9);
        chk("stopping_running", int'(o_running), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_running && n < 100);
        chk("stop_cycles", n, 4);
        chk("stop_counter", int'(o_counter), 0);
        chk("stop_level", int'(o_level), 0);
        chk("stop_period_start", int'(o_period_start), 0);

        // restart with pending level 2, then stop and resume before the wrap
        en = 1'b1;
        @(negedge clk);
        chk("restart_period_start", int'(o_period_start), 1);
        chk("restart_level", int'(o_level), SOFT ? 1 : 2);
        wait_cnt(3);
        en = 1'b0;
        wait_cnt(7);
        en = 1'b1;
        wait_cnt(0);
        chk("resume_running", int'(o_running), 1);
        chk("resume_period_start", int'(o_period_start), 1);
        chk("resume_level", int'(o_level), 2);

        // reset mid-period aborts at once and clears the pending level
        wait_cnt(6);
        pulse_req(2'd3);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_counter", int'(o_counter), 0);
        chk("midrst_level", int'(o_level), 0);
        chk("midrst_running", int'(o_running), 0);
        chk("midrst_tick", int'(o_tick), 0);
        chk("midrst_period_start", int'(o_period_start), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_entry_level", int'(o_level), 0);
        chk("post_rst_entry_start", int'(o_period_start), 1);
        en = 1'b0;
        repeat (50) @(negedge clk);
        chk("final_idle", int'(o_running), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fan_pwm_timebase.md
Name: fan_pwm_timebase

Overview:
- Upstream timebase for the fan duty-cycle comparator stage.
- Generates the free-running PWM counter (0..PERIOD-1) that the comparator thresholds against.
- Emits a period-start strobe and holds the applied fan level. Level changes take effect only at a PWM period boundary, so the downstream fan output never glitches mid-period.
- Sits between the fan-control FSM (level requests) and the comparator/output mux.

Parameters:
- PRESCALE, 100, system clocks per counter increment. Must be ≥1; 1 means increment every cycle.
- PERIOD, 1000, counter modulus; counter runs 0..PERIOD-1. Must be ≤2^CNT_W.
- CNT_W, 10, counter width.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_en  in  1  run request; level-sensitive
- i_level_valid  in  1  qualifies i_level_req for one cycle
- i_level_req  in  2  requested level: 0=off, 1=33%, 2=66%, 3=99%
- o_counter  out  CNT_W  PWM counter to the comparator
- o_tick  out  1  one-cycle pulse on each counter increment
- o_period_start  out  1  one-cycle pulse when the counter wraps to 0
- o_level  out  2  level currently applied; selects the comparator output
- o_running  out  1  high in RUN or STOPPING

Behaviour:
- One clock domain (i_clk). Reset is synchronous and active-high on i_reset.
- Reset state: all outputs 0; prescaler=0; pending level=0; state=IDLE. Reset mid-period aborts immediately, with no wait for a boundary.
- Prescaler: counts 0..PRESCALE-1 while in RUN or STOPPING. At terminal count it wraps and o_tick=1 for that cycle.
- Counter: on a tick it increments. If it was PERIOD-1, it wraps to 0 and o_period_start=1 in the same cycle that o_counter becomes 0 (registered, 1 cycle after the terminal tick).
- Pending level register:
  - Loaded on every cycle where i_level_valid=1, in any state. The last request wins.
  - If a request and a wrap occur in the same cycle, the new request is applied at that wrap (bypass).
- FSM states IDLE, RUN, STOPPING:
  - IDLE: counter=0, prescaler=0, o_level=0, o_running=0. On i_en=1, go to RUN next cycle; o_level loads the pending level (or the same-cycle request) on entry, and the counter starts from 0 with o_period_start=1 on the entry cycle.
  - RUN: counts as above; o_level updates only at a wrap. On i_en=0, go to STOPPING.
  - STOPPING: keeps counting. On wrap, go to IDLE (counter 0, o_level 0, no o_period_start). On i_en=1 before the wrap, return to RUN with no discontinuity.
- Width rules:
  - Counter never exceeds PERIOD-1.
  - Prescaler width is $clog2(PRESCALE), minimum 1.
  - All comparisons are unsigned.

Optional Feature:
- Macro FAN_SOFTSTART_EN.
- Defined: at each wrap, if the pending level exceeds o_level by more than 1, o_level increases by exactly 1 per period until it matches. Decreases and entry from IDLE at level ≤1 apply directly. Entry from IDLE at a higher level starts at 1 and ramps.
- Undefined: the pending level is applied in a single step at the wrap.

Decomposition:
- Shared package fan_pkg:
  - level enum FAN_OFF/FAN_33/FAN_66/FAN_99 (2-bit).
  - FSM state enum.
  - Default PERIOD and PRESCALE constants, which the comparator thresholds also derive from.
- One natural sub-module: fan_prescaler (enable, sync reset, tick output).

Test Plan:
- Reset with PRESCALE=4, PERIOD=10, i_en=1; release reset → o_period_start at the entry cycle, o_tick every 4 cycles, counter 0..9 then 0, period length 40 cycles.
- Running at level 1; i_level_valid with req=3 at counter 4 → o_level stays 1 until wrap, then becomes 3 in the same cycle that o_counter=0.
- Request 2 then request 0 in the same period → o_level=0 at wrap. A request in the exact wrap cycle → applied at that wrap.
- Deassert i_en at counter 3 → continues to 9, then IDLE with counter 0 and o_level 0. Reassert at counter 7 instead → no gap, wraps normally, remains RUN.
- Assert i_reset at counter 6 → next cycle all outputs 0, state IDLE, regardless of pending level.
- With FAN_SOFTSTART_EN defined, request 3 from level 0 → o_level 1, 2, 3 on three successive wraps. A 3→0 request → 0 in one wrap.
